// File: rtl/psum_collector_pkg.sv
// Shared definitions for the psum collector: default geometry, FSM state type,
// psum vector type and the width-generic saturating adder.
package psum_collector_pkg;

    localparam int PEROW_DFLT   = 4;
    localparam int PSUMDWD_DFLT = 24;
    localparam int ACCW_DFLT    = 32;
    localparam int NPASSW_DFLT  = 5;
    localparam int TILEW_DFLT   = 8;

    // Operands are sign-extended to this width before saturation; covers ACCW up to 62.
    localparam int SATW = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } col_state_e;

    typedef struct packed {
        logic [PEROW_DFLT-1:0][PSUMDWD_DFLT-1:0] lane;
    } psum_vec_t;

    function automatic logic signed [SATW-1:0] sat_add(
        input logic signed [SATW-1:0] a,
        input logic signed [SATW-1:0] b,
        input int                     w
    );
        logic signed [SATW-1:0] s;
        logic signed [SATW-1:0] hi;
        logic signed [SATW-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = ~hi;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Psum input vector and accumulated-word output channels, both rdy/ack handshakes.
// slave is the collector side, master is the PE-row / global-buffer side.
interface psum_collector_if #(
    parameter int PEROW   = 4,
    parameter int PSUMDWD = 24,
    parameter int ACCW    = 32
);
    localparam int ROWW = (PEROW > 1) ? $clog2(PEROW) : 1;

    logic                              psum_rdy;
    logic                              psum_ack;
    logic [PEROW-1:0][PSUMDWD-1:0]     psum;
    logic                              out_rdy;
    logic                              out_ack;
    logic [ACCW-1:0]                   out_data;
    logic [ROWW-1:0]                   out_row;
    logic                              out_last;

    modport slave (
        input  psum_rdy, psum, out_ack,
        output psum_ack, out_rdy, out_data, out_row, out_last
    );

    modport master (
        output psum_rdy, psum, out_ack,
        input  psum_ack, out_rdy, out_data, out_row, out_last
    );

endinterface

// File: rtl/psum_collector_acc_lane.sv
// One psum lane: sign-extend, saturating accumulate on i_en, synchronous clear on i_clr.
// Result visible on o_acc the cycle after the enabling edge; no handshake of its own.
module psum_acc_lane
    import psum_collector_pkg::*;
#(
    parameter int PSUMDWD = PSUMDWD_DFLT,
    parameter int ACCW    = ACCW_DFLT
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic signed [PSUMDWD-1:0] i_psum,
    output logic signed [ACCW-1:0]    o_acc
);

    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;
    logic signed [SATW-1:0] acc_w;
    logic signed [SATW-1:0] psum_w;
    logic signed [SATW-1:0] sum_w;

    assign acc_w  = SATW'(acc_q);
    assign psum_w = SATW'(i_psum);
    assign sum_w  = sat_add(acc_w, psum_w, ACCW);

    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = sum_w[ACCW-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/psum_collector.sv
// Accumulates npass psum vectors per tile, then drains PEROW row sums; repeats ntile times.
// Drain starts the cycle after the final pass; out words hold while out_ack=0, no input taken in drain.
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int PEROW   = PEROW_DFLT,
    parameter int PSUMDWD = PSUMDWD_DFLT,
    parameter int ACCW    = ACCW_DFLT,
    parameter int NPASSW  = NPASSW_DFLT,
    parameter int TILEW   = TILEW_DFLT
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [NPASSW-1:0] i_npass,
    input  logic [TILEW-1:0]  i_ntile,
    psum_collector_if.slave   bus,
    output logic              o_busy,
    output logic              o_done
);

    localparam int ROWW = (PEROW > 1) ? $clog2(PEROW) : 1;

    col_state_e        state_q, state_d;
    logic [NPASSW-1:0] npass_q, npass_d;
    logic [NPASSW-1:0] pass_q, pass_d;
    logic [TILEW-1:0]  ntile_q, ntile_d;
    logic [TILEW-1:0]  tile_q, tile_d;
    logic [ROWW-1:0]   row_q, row_d;

    logic              acc_clr;
    logic              acc_en;
    logic [ACCW-1:0]   acc [PEROW];

    logic              psum_ack_w;
    logic              in_drain;
    logic              psum_xfer;
    logic              out_xfer;
    logic              last_row;
    logic              last_tile;

    assign psum_ack_w = (state_q == ST_ACCUM);
    assign in_drain   = (state_q == ST_DRAIN);
    assign psum_xfer  = psum_ack_w && bus.psum_rdy;
    assign out_xfer   = in_drain && bus.out_ack;
    assign last_row   = (row_q == ROWW'(PEROW - 1));
    assign last_tile  = (tile_q == ntile_q - TILEW'(1));

    for (genvar r = 0; r < PEROW; r++) begin : g_lane
        psum_acc_lane #(
            .PSUMDWD(PSUMDWD),
            .ACCW   (ACCW)
        ) u_lane (
            .i_clk (i_clk),
            .i_rstn(i_rstn),
            .i_clr (acc_clr),
            .i_en  (acc_en),
            .i_psum(bus.psum[r]),
            .o_acc (acc[r])
        );
    end

    always_comb begin
        state_d = state_q;
        npass_d = npass_q;
        ntile_d = ntile_q;
        pass_d  = pass_q;
        tile_d  = tile_q;
        row_d   = row_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    npass_d = (i_npass == '0) ? NPASSW'(1) : i_npass;
                    ntile_d = (i_ntile == '0) ? TILEW'(1) : i_ntile;
                    pass_d  = '0;
                    tile_d  = '0;
                    row_d   = '0;
                    acc_clr = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (psum_xfer) begin
                    acc_en = 1'b1;
                    pass_d = pass_q + NPASSW'(1);
                    if (pass_q == npass_q - NPASSW'(1)) begin
                        row_d   = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_xfer) begin
                    row_d = row_q + ROWW'(1);
                    if (last_row) begin
                        if (last_tile) begin
                            state_d = ST_DONE;
                        end else begin
                            // Next tile starts from cleared accumulators.
                            tile_d  = tile_q + TILEW'(1);
                            pass_d  = '0;
                            acc_clr = 1'b1;
                            state_d = ST_ACCUM;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            npass_q <= '0;
            ntile_q <= '0;
            pass_q  <= '0;
            tile_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            npass_q <= npass_d;
            ntile_q <= ntile_d;
            pass_q  <= pass_d;
            tile_q  <= tile_d;
            row_q   <= row_d;
        end
    end

    // Output word is gated so the bus reads all-zero outside drain.
    assign bus.psum_ack = psum_ack_w;
    assign bus.out_rdy  = in_drain;
    assign bus.out_data = in_drain ? acc[row_q] : '0;
    assign bus.out_row  = in_drain ? row_q : '0;
    assign bus.out_last = in_drain && last_row && last_tile;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: default-geometry instance plus a 16/16-bit
// instance for saturation.
module tb_psum_collector;
    import psum_collector_pkg::*;

    localparam int P   = 4;
    localparam int DW  = 24;
    localparam int AW  = 32;
    localparam int DW2 = 16;
    localparam int AW2 = 16;
    localparam int RW  = 2;

    typedef struct {
        logic [AW-1:0] data;
        logic [RW-1:0] row;
        logic          last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn, start, start2;
    logic       busy, done, busy2, done2;
    logic [4:0] npass;
    logic [7:0] ntile;
    int         n_checks = 0;
    int         n_pass = 0;
    longint     acc_m [P];
    exp_t       sb [$];
    int         bp_pat [8] = '{0, 0, 1, 0, 1, 1, 0, 1};

    psum_collector_if #(.PEROW(P), .PSUMDWD(DW),  .ACCW(AW))  ifc ();
    psum_collector_if #(.PEROW(P), .PSUMDWD(DW2), .ACCW(AW2)) ifc2 ();

    psum_collector #(.PEROW(P), .PSUMDWD(DW), .ACCW(AW), .NPASSW(5), .TILEW(8)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_npass(npass), .i_ntile(ntile),
        .bus(ifc), .o_busy(busy), .o_done(done)
    );

    psum_collector #(.PEROW(P), .PSUMDWD(DW2), .ACCW(AW2), .NPASSW(5), .TILEW(8)) dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start2), .i_npass(npass), .i_ntile(ntile),
        .bus(ifc2), .o_busy(busy2), .o_done(done2)
    );

    always #5 clk = ~clk;

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_vec(input int l0, input int l1, input int l2, input int l3);
        int lv [P];
        bit got;
        lv = '{l0, l1, l2, l3};
        ifc.psum_rdy = 1'b1;
        for (int i = 0; i < P; i++) begin
            ifc.psum[i] = DW'(lv[i]);
            acc_m[i] += longint'(lv[i]);
        end
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = ifc.psum_ack;
        end
        n_checks++;
        if (!got) $display("FAIL psum_ack_wait: ack=0 for 50 cycles, required 1");
        else n_pass++;
        @(posedge clk); #1 ifc.psum_rdy = 1'b0;
    endtask

    task automatic push_tile(input bit last_tile);
        exp_t e;
        for (int r = 0; r < P; r++) begin
            e.data = AW'(acc_m[r]);
            e.row  = RW'(r);
            e.last = last_tile && (r == P - 1);
            sb.push_back(e);
            acc_m[r] = 0;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ifc.psum_ack !== 1'b0 || ifc.out_rdy !== 1'b0 ||
            ifc.out_data !== '0 || ifc.out_row !== '0 || ifc.out_last !== 1'b0)
            $display("FAIL reset_state: busy=%0b done=%0b ack=%0b rdy=%0b data=%0d row=%0d last=%0b, required all 0",
                     busy, done, ifc.psum_ack, ifc.out_rdy, ifc.out_data, ifc.out_row, ifc.out_last);
        else n_pass++;
        n_checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || ifc2.out_rdy !== 1'b0 || ifc2.out_data !== '0)
            $display("FAIL reset_state2: busy=%0b done=%0b rdy=%0b data=%0d, required all 0",
                     busy2, done2, ifc2.out_rdy, ifc2.out_data);
        else n_pass++;
        @(negedge clk) rstn = 1'b1;
        ifc.psum_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ifc.psum_ack !== 1'b0) $display("FAIL idle_no_ack: psum_ack=%0b, required 0", ifc.psum_ack);
        else n_pass++;
        ifc.psum_rdy = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        npass = 5'd1; ntile = 8'd1; ifc.out_ack = 1'b1;
        pulse_start();
        send_vec(1, 2, 3, 4);
        push_tile(1'b1);
        for (int r = 0; r < P; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (ifc.out_rdy !== 1'b1 || ifc.out_data !== e.data || ifc.out_row !== e.row || ifc.out_last !== e.last)
                $display("FAIL basic_word: rdy=%0b data=%0d row=%0d last=%0b, required rdy=1 data=%0d row=%0d last=%0b",
                         ifc.out_rdy, $signed(ifc.out_data), ifc.out_row, ifc.out_last, $signed(e.data), e.row, e.last);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || ifc.out_rdy !== 1'b0) $display("FAIL basic_done: done=%0b rdy=%0b, required done=1 rdy=0", done, ifc.out_rdy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_idle: done=%0b busy=%0b, required 0 0", done, busy);
        else n_pass++;
    endtask

    task automatic test_accumulate();
        exp_t e;
        npass = 5'd3; ntile = 8'd1; ifc.out_ack = 1'b1;
        pulse_start();
        send_vec(1, 1, 1, 1);
        send_vec(2, -1, 0, 5);
        send_vec(-4, 0, 7, 1);
        push_tile(1'b1);
        ifc.psum_rdy = 1'b1;
        for (int c = 0; c < 50 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (ifc.out_rdy && ifc.out_ack) begin
                e = sb.pop_front();
                n_checks++;
                if (ifc.out_data !== e.data || ifc.out_row !== e.row || ifc.out_last !== e.last || ifc.psum_ack !== 1'b0)
                    $display("FAIL accum_word: data=%0d row=%0d last=%0b psum_ack=%0b, required data=%0d row=%0d last=%0b psum_ack=0",
                             $signed(ifc.out_data), ifc.out_row, ifc.out_last, ifc.psum_ack, $signed(e.data), e.row, e.last);
                else n_pass++;
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL accum_drain: %0d words outstanding, required 0", sb.size());
            sb.delete();
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL accum_done: done=%0b, required 1", done);
        else n_pass++;
        ifc.psum_rdy = 1'b0;
    endtask

    task automatic test_saturation();
        logic [AW2-1:0] exp2 [P];
        int got;
        exp2 = '{16'h7fff, 16'h8000, 16'd200, 16'hfff6};
        npass = 5'd2; ntile = 8'd1; ifc2.out_ack = 1'b1;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ifc2.psum_rdy = 1'b1;
            ifc2.psum[0] = 16'h7fff;
            ifc2.psum[1] = 16'h8000;
            ifc2.psum[2] = 16'd100;
            ifc2.psum[3] = 16'hfffb;
            @(negedge clk);
            n_checks++;
            if (ifc2.psum_ack !== 1'b1) $display("FAIL sat_ack: psum_ack=%0b, required 1", ifc2.psum_ack);
            else n_pass++;
            @(posedge clk); #1 ifc2.psum_rdy = 1'b0;
        end
        got = 0;
        for (int c = 0; c < 20 && got < P; c++) begin
            @(negedge clk);
            if (ifc2.out_rdy && ifc2.out_ack) begin
                n_checks++;
                if (ifc2.out_data !== exp2[got] || ifc2.out_row !== RW'(got))
                    $display("FAIL sat_word: data=%0d row=%0d, required data=%0d row=%0d",
                             $signed(ifc2.out_data), ifc2.out_row, $signed(exp2[got]), got);
                else n_pass++;
                got++;
            end
        end
        n_checks++;
        if (got != P) $display("FAIL sat_drain: %0d words seen, required %0d", got, P);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done2 !== 1'b1) $display("FAIL sat_done: done=%0b, required 1", done2);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic held;
        logic [AW-1:0] hd;
        logic [RW-1:0] hr;
        npass = 5'd1; ntile = 8'd1; ifc.out_ack = 1'b1;
        pulse_start();
        send_vec(10, -20, 30, -40);
        push_tile(1'b1);
        ifc.psum_rdy = 1'b1;
        start = 1'b1;
        held = 1'b0; hd = '0; hr = '0;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            @(negedge clk);
            n_checks++;
            if (ifc.psum_ack !== 1'b0 || busy !== 1'b1)
                $display("FAIL bp_no_input: psum_ack=%0b busy=%0b, required 0 1", ifc.psum_ack, busy);
            else n_pass++;
            if (held) begin
                n_checks++;
                if (ifc.out_rdy !== 1'b1 || ifc.out_data !== hd || ifc.out_row !== hr)
                    $display("FAIL bp_hold: rdy=%0b data=%0d row=%0d, required rdy=1 data=%0d row=%0d",
                             ifc.out_rdy, $signed(ifc.out_data), ifc.out_row, $signed(hd), hr);
                else n_pass++;
            end
            held = ifc.out_rdy && !ifc.out_ack;
            hd = ifc.out_data;
            hr = ifc.out_row;
            if (ifc.out_rdy && ifc.out_ack) begin
                e = sb.pop_front();
                n_checks++;
                if (ifc.out_data !== e.data || ifc.out_row !== e.row || ifc.out_last !== e.last)
                    $display("FAIL bp_word: data=%0d row=%0d last=%0b, required data=%0d row=%0d last=%0b",
                             $signed(ifc.out_data), ifc.out_row, ifc.out_last, $signed(e.data), e.row, e.last);
                else n_pass++;
            end
            @(posedge clk); #1 ifc.out_ack = (bp_pat[c % 8] != 0);
        end
        start = 1'b0;
        ifc.psum_rdy = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL bp_drain: %0d words outstanding, required 0", sb.size());
            sb.delete();
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL bp_done: done=%0b, required 1", done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL bp_start_ignored: busy=%0b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_multi_tile();
        exp_t e;
        npass = 5'd2; ntile = 8'd2; ifc.out_ack = 1'b1;
        pulse_start();
        npass = 5'd7; ntile = 8'd9;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                send_vec(5, 6, 7, 8);
                send_vec(1, 1, 1, 1);
            end else begin
                send_vec(100, -3, 0, 2);
                send_vec(-1, 4, 9, 9);
            end
            push_tile(t == 1);
            for (int c = 0; c < 50 && sb.size() > 0; c++) begin
                @(negedge clk);
                if (ifc.out_rdy && ifc.out_ack) begin
                    e = sb.pop_front();
                    n_checks++;
                    if (ifc.out_data !== e.data || ifc.out_row !== e.row || ifc.out_last !== e.last)
                        $display("FAIL tile%0d_word: data=%0d row=%0d last=%0b, required data=%0d row=%0d last=%0b",
                                 t, $signed(ifc.out_data), ifc.out_row, ifc.out_last, $signed(e.data), e.row, e.last);
                    else n_pass++;
                end
            end
            n_checks++;
            if (sb.size() != 0) begin
                $display("FAIL tile%0d_drain: %0d words outstanding, required 0", t, sb.size());
                sb.delete();
            end else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL multi_done: done=%0b, required 1", done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        npass = 5'd3; ntile = 8'd1; ifc.out_ack = 1'b1;
        pulse_start();
        send_vec(50, 50, 50, 50);
        for (int r = 0; r < P; r++) acc_m[r] = 0;
        rstn = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ifc.psum_ack !== 1'b0 || ifc.out_rdy !== 1'b0 ||
            ifc.out_data !== '0 || ifc.out_row !== '0 || ifc.out_last !== 1'b0)
            $display("FAIL midreset_state: busy=%0b done=%0b ack=%0b rdy=%0b data=%0d row=%0d last=%0b, required all 0",
                     busy, done, ifc.psum_ack, ifc.out_rdy, ifc.out_data, ifc.out_row, ifc.out_last);
        else n_pass++;
        @(negedge clk) rstn = 1'b1;
        npass = 5'd0; ntile = 8'd0;
        pulse_start();
        send_vec(3, -3, 9, 1);
        push_tile(1'b1);
        for (int c = 0; c < 50 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (ifc.out_rdy && ifc.out_ack) begin
                e = sb.pop_front();
                n_checks++;
                if (ifc.out_data !== e.data || ifc.out_row !== e.row || ifc.out_last !== e.last)
                    $display("FAIL restart_word: data=%0d row=%0d last=%0b, required data=%0d row=%0d last=%0b",
                             $signed(ifc.out_data), ifc.out_row, ifc.out_last, $signed(e.data), e.row, e.last);
                else n_pass++;
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL restart_drain: %0d words outstanding, required 0", sb.size());
            sb.delete();
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL restart_done: done=%0b, required 1", done);
        else n_pass++;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; start2 = 1'b0;
        npass = 5'd0; ntile = 8'd0;
        ifc.psum_rdy = 1'b0;  ifc.psum = '0;  ifc.out_ack = 1'b0;
        ifc2.psum_rdy = 1'b0; ifc2.psum = '0; ifc2.out_ack = 1'b0;
        for (int r = 0; r < P; r++) acc_m[r] = 0;
        test_reset();
        test_basic();
        test_accumulate();
        test_saturation();
        test_backpressure();
        test_multi_tile();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Downstream neighbour of the PE array row output.
- Accepts PEROW-wide partial-sum vectors over a rdy/ack handshake and accumulates them over a configured number of passes.
- Then drains the accumulated row sums one word per handshake toward the global buffer.
- Repeats for a configured number of output tiles, then signals done.

Parameters:
PEROW, 4, number of psum lanes per input vector
PSUMDWD, 24, signed width of each incoming psum lane
ACCW, 32, signed accumulator / output word width (ACCW >= PSUMDWD)
NPASSW, 5, width of pass-count config
TILEW, 8, width of tile-count config

Ports:
i_clk  input  1  clock
i_rstn  input  1  reset (asynchronous, active-low)
i_start  input  1  one-cycle start pulse; sampled only in IDLE
i_npass  input  NPASSW  passes per tile; 0 treated as 1; sampled at start
i_ntile  input  TILEW  tiles per job; 0 treated as 1; sampled at start
i_psum_rdy  input  1  upstream psum vector valid
o_psum_ack  output  1  psum vector accepted this cycle when i_psum_rdy=1
i_psum  input  PEROW x PSUMDWD  signed psum vector
o_out_rdy  output  1  output word valid
i_out_ack  input  1  downstream accepts output word
o_out_data  output  ACCW  accumulated row sum
o_out_row  output  clog2(PEROW)  lane index of o_out_data
o_out_last  output  1  final word of final tile
o_busy  output  1  state != IDLE
o_done  output  1  one-cycle pulse after final word transferred

Behaviour:
- Reset: state IDLE; all counters and accumulators 0; every output 0.
- Transfer rule: a transfer occurs on a cycle where rdy && ack.
- Sender rules: the sender must hold rdy and data stable until the transfer. This block obeys the same rules on the out port.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - o_psum_ack=0.
  - On i_start: latch npass/ntile (0 becomes 1), clear accumulators, pass_cnt=0, tile_cnt=0, go to ACCUM.
- ACCUM:
  - o_psum_ack=1 (combinational on state).
  - Each transfer: acc[r] <= sat(acc[r] + sext(i_psum[r])) for all r; pass_cnt++.
  - On the transfer with pass_cnt==npass-1: go to DRAIN, row_idx=0.
- Arithmetic:
  - Lanes are sign-extended from PSUMDWD to ACCW.
  - Addition saturates to [-2^(ACCW-1), 2^(ACCW-1)-1]; no wrap.
  - The first pass of each tile adds onto cleared accumulators.
- DRAIN:
  - o_psum_ack=0.
  - o_out_rdy=1, o_out_data=acc[row_idx], o_out_row=row_idx.
  - o_out_last=1 only when row_idx==PEROW-1 and tile_cnt==ntile-1.
  - Each transfer: row_idx++.
  - On the transfer of row PEROW-1:
    - If last tile: go to DONE.
    - Otherwise: tile_cnt++, clear accumulators, pass_cnt=0, go to ACCUM.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Latency:
  - Final-pass transfer at cycle N gives o_out_rdy=1 at N+1 with row 0.
  - Minimum drain is PEROW cycles.
  - Drain of the last tile ending at cycle M gives o_done at M+1.
- Backpressure: if i_out_ack=0, outputs hold stable indefinitely; no input is accepted during DRAIN.
- Boundaries:
  - i_start outside IDLE is ignored.
  - i_psum_rdy in IDLE/DRAIN/DONE is not acked.
  - Config changes after start have no effect.
- Reset mid-operation: asynchronous return to reset state; partial sums discarded; no o_done.

Decomposition:
- Shared package PECfg holds:
  - PEROW, PSUMDWD, ACCW defaults.
  - typedef of the collector state enum.
  - typedef struct PsumVec {logic signed [PSUMDWD-1:0] lane[PEROW]}.
  - Saturating-add function sat_add(ACCW).
- One natural sub-module: psum_acc_lane (one sign-extend + saturating accumulator + clear/enable), instantiated PEROW times via generate.
- FSM, counters and output mux remain in the top.

Test Plan:
- Basic: npass=1, ntile=1, psum {1,2,3,4}, out_ack held 1 -> out words 1,2,3,4 on rows 0..3 on consecutive cycles; last on row 3; done one cycle later.
- Accumulate: npass=3, vectors {1,1,1,1},{2,-1,0,5},{-4,0,7,1} -> outputs {-1,0,8,7}; ack low during drain.
- Saturation: PSUMDWD=16, ACCW=16, npass=2, lane0 32767 twice, lane1 -32768 twice -> 32767, -32768.
- Backpressure: toggle i_out_ack 1,0,0,1 during drain -> data/row stable while ack=0; each word appears exactly once; no input acked.
- Multi-tile: ntile=2, npass=2 -> second tile sums exclude first tile; o_out_last only on final row of tile 2.
- Robustness:
  - Reset pulse during ACCUM after 1 pass -> outputs 0, state IDLE.
  - A fresh start then produces correct sums.
  - i_start during DRAIN is ignored.
  - npass=0 behaves as 1.
